// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two writeback sources, the register file write
// port and the decode-stage forwarding logic.
//   slave  : the arbiter (consumes requests, drives readies/write port/fwd)
//   master : the requesters / environment (drives requests, hold, read indices)
// Signals:
//   hold                       pipeline freeze, blocks new grants
//   alu_valid/res/data, alu_ready  ALU writeback handshake
//   mem_valid/res/data, mem_ready  load writeback handshake
//   regWrite/writeRes/writeData    registered register-file write port
//   readRes1/2, fwd1/2, fwdData    bypass query and result
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              hold;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_res;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_res;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              regWrite;
  logic [ADDR_W-1:0] writeRes;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readRes1;
  logic [ADDR_W-1:0] readRes2;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] fwdData;

  modport slave (
    input  hold,
    input  alu_valid, alu_res, alu_data,
    output alu_ready,
    input  mem_valid, mem_res, mem_data,
    output mem_ready,
    output regWrite, writeRes, writeData,
    input  readRes1, readRes2,
    output fwd1, fwd2, fwdData
  );

  modport master (
    output hold,
    output alu_valid, alu_res, alu_data,
    input  alu_ready,
    output mem_valid, mem_res, mem_data,
    input  mem_ready,
    input  regWrite, writeRes, writeData,
    output readRes1, readRes2,
    input  fwd1, fwd2, fwdData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU result path and the load return path. The granted request is
// registered for one cycle onto regWrite/writeRes/writeData, and bypass flags
// tell the decode stage when that in-flight write matches its read indices.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    regfile_write_arbiter_if.slave (handshakes, write port, bypass)
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_write_arbiter_if.slave       bus
);

  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_MEM = 1'b1;

  logic              last_q,      last_d;
  logic              regWrite_q,  regWrite_d;
  logic [ADDR_W-1:0] writeRes_q,  writeRes_d;
  logic [DATA_W-1:0] writeData_q, writeData_d;

  logic alu_gnt, mem_gnt;

  // On conflict the requester that did not win last time goes first, so
  // continuous contention alternates and nobody waits more than one cycle.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!reset && !bus.hold) begin
      if (bus.alu_valid && bus.mem_valid) begin
        alu_gnt = (last_q == LAST_MEM);
        mem_gnt = (last_q == LAST_ALU);
      end else begin
        alu_gnt = bus.alu_valid;
        mem_gnt = bus.mem_valid;
      end
    end
  end

  always_comb begin
    last_d      = last_q;
    regWrite_d  = 1'b0;
    writeRes_d  = writeRes_q;
    writeData_d = writeData_q;
    if (alu_gnt) begin
      last_d      = LAST_ALU;
      regWrite_d  = (bus.alu_res != '0);  // r0 writes are consumed but dropped
      writeRes_d  = bus.alu_res;
      writeData_d = bus.alu_data;
    end else if (mem_gnt) begin
      last_d      = LAST_MEM;
      regWrite_d  = (bus.mem_res != '0);
      writeRes_d  = bus.mem_res;
      writeData_d = bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= LAST_MEM;  // ALU wins the first conflict after reset
      regWrite_q  <= 1'b0;
      writeRes_q  <= '0;
      writeData_q <= '0;
    end else begin
      last_q      <= last_d;
      regWrite_q  <= regWrite_d;
      writeRes_q  <= writeRes_d;
      writeData_q <= writeData_d;
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  assign bus.regWrite  = regWrite_q;
  assign bus.writeRes  = writeRes_q;
  assign bus.writeData = writeData_q;

  // regWrite_q is never set for r0, so the bypass never fires for index 0.
  assign bus.fwd1    = regWrite_q && (writeRes_q == bus.readRes1);
  assign bus.fwd2    = regWrite_q && (writeRes_q == bus.readRes2);
  assign bus.fwdData = writeData_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.hold      = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_res   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_res   = '0;
    bus.mem_data  = '0;
    bus.readRes1  = '0;
    bus.readRes2  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    bus.alu_res   = 5'd1;
    bus.mem_res   = 5'd2;
    @(negedge clk);
    #1;
    n_chk++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready got %0b want 0", bus.alu_ready); end
    n_chk++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready got %0b want 0", bus.mem_ready); end
    n_chk++; if (bus.regWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regWrite got %0b want 0", bus.regWrite); end
    n_chk++; if (bus.writeRes !== 5'd0) begin n_fail++; $display("FAIL rst_writeRes got %0d want 0", bus.writeRes); end
    n_chk++; if (bus.writeData !== 32'd0) begin n_fail++; $display("FAIL rst_writeData got %0h want 0", bus.writeData); end
    n_chk++; if (bus.fwd1 !== 1'b0 || bus.fwd2 !== 1'b0) begin n_fail++; $display("FAIL rst_fwd got %0b%0b want 00", bus.fwd1, bus.fwd2); end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_alu();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_res = 5'd5; bus.alu_data = 32'h1234;
    #1;
    n_chk++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready got %0b want 1", bus.alu_ready); end
    n_chk++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL single_mem_ready got %0b want 0", bus.mem_ready); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    n_chk++; if (bus.regWrite !== 1'b1) begin n_fail++; $display("FAIL single_regWrite got %0b want 1", bus.regWrite); end
    n_chk++; if (bus.writeRes !== 5'd5) begin n_fail++; $display("FAIL single_writeRes got %0d want 5", bus.writeRes); end
    n_chk++; if (bus.writeData !== 32'h1234) begin n_fail++; $display("FAIL single_writeData got %0h want 1234", bus.writeData); end
    @(negedge clk);
    n_chk++; if (bus.regWrite !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %0b want 0", bus.regWrite); end
    n_chk++; if (bus.writeRes !== 5'd5) begin n_fail++; $display("FAIL single_res_hold got %0d want 5", bus.writeRes); end
  endtask

  task automatic test_alternate();
    logic       exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] exp_res [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
    logic [31:0] exp_dat [4] = '{32'hA, 32'hB, 32'hA, 32'hB};
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_res = 5'd3; bus.alu_data = 32'hA;
    bus.mem_valid = 1'b1; bus.mem_res = 5'd4; bus.mem_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (bus.alu_ready !== exp_alu[i] || bus.mem_ready !== ~exp_alu[i]) begin
        n_fail++; $display("FAIL alt_grant[%0d] got alu=%0b mem=%0b want alu=%0b mem=%0b",
                           i, bus.alu_ready, bus.mem_ready, exp_alu[i], ~exp_alu[i]);
      end
      @(negedge clk);
      n_chk++; if (bus.regWrite !== 1'b1 || bus.writeRes !== exp_res[i] || bus.writeData !== exp_dat[i]) begin
        n_fail++; $display("FAIL alt_write[%0d] got we=%0b res=%0d data=%0h want we=1 res=%0d data=%0h",
                           i, bus.regWrite, bus.writeRes, bus.writeData, exp_res[i], exp_dat[i]);
      end
    end
    idle_inputs();
  endtask

  // Last grant was MEM here; an r0 MEM write must still flip priority to ALU.
  task automatic test_reg0();
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_res = 5'd0; bus.mem_data = 32'hFFFF;
    #1;
    n_chk++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL r0_mem_ready got %0b want 1", bus.mem_ready); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.readRes1  = 5'd0;
    #1;
    n_chk++; if (bus.regWrite !== 1'b0) begin n_fail++; $display("FAIL r0_regWrite got %0b want 0", bus.regWrite); end
    n_chk++; if (bus.writeData !== 32'hFFFF) begin n_fail++; $display("FAIL r0_writeData got %0h want ffff", bus.writeData); end
    n_chk++; if (bus.fwd1 !== 1'b0) begin n_fail++; $display("FAIL r0_fwd1 got %0b want 0", bus.fwd1); end
    bus.alu_valid = 1'b1; bus.alu_res = 5'd1; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_res = 5'd2; bus.mem_data = 32'h22;
    #1;
    n_chk++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL r0_next_conflict got alu=%0b mem=%0b want alu=1 mem=0", bus.alu_ready, bus.mem_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_forward();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_res = 5'd7; bus.alu_data = 32'h55;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.readRes1 = 5'd7; bus.readRes2 = 5'd8;
    #1;
    n_chk++; if (bus.fwd1 !== 1'b1) begin n_fail++; $display("FAIL fwd_fwd1 got %0b want 1", bus.fwd1); end
    n_chk++; if (bus.fwd2 !== 1'b0) begin n_fail++; $display("FAIL fwd_fwd2 got %0b want 0", bus.fwd2); end
    n_chk++; if (bus.fwdData !== 32'h55) begin n_fail++; $display("FAIL fwd_data got %0h want 55", bus.fwdData); end
    bus.readRes1 = 5'd8; bus.readRes2 = 5'd7;
    #1;
    n_chk++; if (bus.fwd1 !== 1'b0 || bus.fwd2 !== 1'b1) begin
      n_fail++; $display("FAIL fwd_swap got %0b%0b want 01", bus.fwd1, bus.fwd2);
    end
    idle_inputs();
  endtask

  // Pre-hold grant is ALU (r10), so MEM must win once hold drops.
  task automatic test_hold();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_res = 5'd10; bus.alu_data = 32'h10;
    @(negedge clk);
    bus.hold = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_res = 5'd12; bus.mem_data = 32'h12;
    bus.alu_res = 5'd11; bus.alu_data = 32'h11;
    #1;
    n_chk++; if (bus.regWrite !== 1'b1 || bus.writeRes !== 5'd10) begin
      n_fail++; $display("FAIL hold_inflight got we=%0b res=%0d want we=1 res=10", bus.regWrite, bus.writeRes);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_ready[%0d] got alu=%0b mem=%0b want 0 0", i, bus.alu_ready, bus.mem_ready);
      end
      @(negedge clk);
      n_chk++; if (bus.regWrite !== 1'b0) begin n_fail++; $display("FAIL hold_regWrite[%0d] got %0b want 0", i, bus.regWrite); end
    end
    bus.hold = 1'b0;
    #1;
    n_chk++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got alu=%0b mem=%0b want alu=0 mem=1", bus.alu_ready, bus.mem_ready);
    end
    @(negedge clk);
    n_chk++; if (bus.regWrite !== 1'b1 || bus.writeRes !== 5'd12) begin
      n_fail++; $display("FAIL hold_release_write got we=%0b res=%0d want we=1 res=12", bus.regWrite, bus.writeRes);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_res = 5'd9; bus.alu_data = 32'h99;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (bus.regWrite !== 1'b0 || bus.writeRes !== 5'd0 || bus.writeData !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_out got we=%0b res=%0d data=%0h want 0 0 0", bus.regWrite, bus.writeRes, bus.writeData);
    end
    bus.alu_valid = 1'b1; bus.alu_res = 5'd1; bus.alu_data = 32'h1;
    bus.mem_valid = 1'b1; bus.mem_res = 5'd2; bus.mem_data = 32'h2;
    #1;
    n_chk++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_conflict got alu=%0b mem=%0b want alu=1 mem=0", bus.alu_ready, bus.mem_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_alu();
    test_alternate();
    test_reg0();
    test_forward();
    test_hold();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU result path and the load/memory return path. Arbitration is round-robin with a valid/ready handshake, and the granted write is registered for one cycle. It also provides bypass flags so the operand-read stage can forward a write that has not yet landed in the register file. It sits between the EX/MEM writeback sources and the `register` block's `regWrite`/`writeRes`/`writeData` inputs.

## Interface
Parameters:
- `DATA_W`, 32: writeback data width.
- `ADDR_W`, 5: register index width (32 registers).

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `hold`  in  1  pipeline freeze; while high, no grant is issued.
- `alu_valid`  in  1  ALU writeback request.
- `alu_res`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load writeback request.
- `mem_res`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load data.
- `mem_ready`  out  1  load request accepted this cycle.
- `regWrite`  out  1  write enable to the register file.
- `writeRes`  out  ADDR_W  register file write index.
- `writeData`  out  DATA_W  register file write data.
- `readRes1`, `readRes2`  in  ADDR_W  indices being read by the decode stage.
- `fwd1`, `fwd2`  out  1  the in-flight write targets `readRes1` / `readRes2`.
- `fwdData`  out  DATA_W  forwarding data (equals `writeData`).

## Operation
- State:
  - `last` (1 bit): 0 = ALU, 1 = MEM. This is the most recently granted requester.
  - Output stage: `regWrite`, `writeRes`, `writeData`.
- Grant logic is combinational from `alu_valid`, `mem_valid`, `hold`, `reset` and `last`:
  - If `reset` or `hold` is high: both ready outputs are 0.
  - If only one requester is valid: that requester gets ready = 1.
  - If both are valid: the requester not equal to `last` wins. The loser's ready is 0, and it must keep valid, res and data stable.
  - At most one ready is high per cycle.
  - Requesters must not make valid depend on ready.
- Handshake: a transfer occurs on a rising edge where valid && ready.
  - `last` updates to the granted requester.
  - The output stage loads the transfer: `regWrite` = (res != 0), `writeRes` = res, `writeData` = data.
- Register 0:
  - A transfer with res = 0 is accepted and consumed, and it still updates `last`.
  - `regWrite` stays 0 for it. `writeRes` and `writeData` still load.
- No transfer on an edge (including while `hold` is high): `regWrite` goes to 0. `writeRes` and `writeData` hold their previous values.
- Forwarding is combinational from registered state:
  - `fwd1` = `regWrite` && (`writeRes` == `readRes1`); `fwd2` likewise for `readRes2`.
  - `fwdData` = `writeData`.
  - `fwd1`/`fwd2` are never set for index 0.
- No internal buffering. A requester that is not granted is back-pressured through ready = 0.

## Timing
- Reset values (on the first edge with `reset` high):
  - `regWrite` = 0, `writeRes` = 0, `writeData` = 0, `last` = 1 (MEM), so the ALU wins the first conflict.
  - `alu_ready` = `mem_ready` = 0 combinationally while `reset` is high.
  - `fwd1` = `fwd2` = 0 from the following cycle.
- Latency: a transfer at edge N makes `regWrite` high during cycle N+1. The register file commits at edge N+1. `regWrite` pulses for exactly one cycle per accepted write.
- Throughput: one write per cycle. Back-to-back writes to the same register both reach the port, in grant order.
- Both valid continuously: grants alternate ALU, MEM, ALU, ...; neither requester is starved for more than 1 cycle.
- `hold` asserted mid-stream: a write already in the output stage still completes in the next cycle. No new grant is issued until `hold` drops. `last` is unchanged across the hold.
- Reset mid-operation: a pending output-stage write is discarded (`regWrite` = 0 after the reset edge) and `last` returns to 1.

## Test plan
- Reset, then `alu_valid` = 1, `alu_res` = 5, `alu_data` = 0x1234 for one cycle -> `alu_ready` = 1 that cycle; the next cycle shows `regWrite` = 1, `writeRes` = 5, `writeData` = 0x1234; the cycle after shows `regWrite` = 0.
- Both valid for 4 cycles with ALU→r3/0xA and MEM→r4/0xB held -> grants alternate ALU, MEM, ALU, MEM starting with ALU; `writeRes` sequence is 3, 4, 3, 4.
- MEM transfer with res = 0, data 0xFFFF -> `mem_ready` = 1, `regWrite` stays 0, `fwd1` = 0 with `readRes1` = 0; the next conflict is granted to ALU.
- ALU write to r7 (0x55) with `readRes1` = 7 and `readRes2` = 8 in the following cycle -> `fwd1` = 1, `fwd2` = 0, `fwdData` = 0x55.
- `hold` high for 3 cycles with both requesters valid -> both readies are 0 and `regWrite` is 0 after the first cycle; the grant after `hold` drops goes to the requester not equal to the pre-hold `last`.
- `reset` asserted on the cycle right after an accepted write to r9 -> `regWrite` = 0, `writeRes` = 0, `writeData` = 0 after that edge; the first subsequent conflict is granted to ALU.
